// File: rtl/semaforo_monitor_if.sv
// Observation bus between the light controller outputs and the receive-side monitor.
interface semaforo_monitor_if;
    logic [41:0] lights;
    logic        clr_err;
    logic [2:0]  phase;
    logic        phase_valid;
    logic        locked;
    logic        err_pattern;
    logic        err_seq;
    logic        err_time;
    logic        err_conflict;
    logic        fault;
    logic        err_pulse;
    logic [15:0] cycles_done;

    modport master (
        output lights, clr_err,
        input  phase, phase_valid, locked, err_pattern, err_seq, err_time,
               err_conflict, fault, err_pulse, cycles_done
    );

    modport slave (
        input  lights, clr_err,
        output phase, phase_valid, locked, err_pattern, err_seq, err_time,
               err_conflict, fault, err_pulse, cycles_done
    );
endinterface

// File: rtl/semaforo_monitor.sv
// Decodes the 14 lane codes back to phase S1..S6; checks pattern, order, dwell and conflicts.
// Input-to-output latency 2 cycles; passive observer, never stalls the controller.
module semaforo_monitor #(
    parameter int T_S1 = 31,
    parameter int T_S2 = 4,
    parameter int T_S3 = 31,
    parameter int T_S4 = 4,
    parameter int T_S5 = 16,
    parameter int T_S6 = 4
) (
    input  logic              clk,
    input  logic              rst,
    semaforo_monitor_if.slave mon
);
    localparam logic [2:0]  RED = 3'b100;
    localparam logic [2:0]  YEL = 3'b010;
    localparam logic [2:0]  GRN = 3'b001;
    localparam logic [2:0]  PH_INV = 3'd7;
    // Lane masks, bit i = lane i (0 F1, 1 F2, 2 F6, 3 F9, 4..13 P1..P10)
    localparam logic [13:0] M_A   = 14'h14A5;
    localparam logic [13:0] M_B   = 14'h0A5A;
    localparam logic [13:0] M_C   = 14'h2100;
    localparam logic [13:0] M_VEH = 14'h000F;
    localparam logic [13:0] M_PED = 14'h3FF0;
    localparam logic [13:0] M_S6G = 14'h14A0;
    localparam logic [13:0] M_S6Y = 14'h2B50;
    localparam logic [13:0] M_X1  = 14'h2B5A;
    localparam logic [13:0] M_X2  = 14'h35A5;

    typedef enum logic {SYNC, TRACK} state_t;

    state_t      r_state;
    logic [41:0] r_lights_q;
    logic        r_q_vld;
    logic [2:0]  r_phase;
    logic        r_phase_valid;
    logic        r_locked;
    logic [7:0]  r_dwell;
    logic        r_err_pattern, r_err_seq, r_err_time, r_err_conflict;
    logic        r_fault, r_err_pulse;
    logic [15:0] r_cycles;

    logic [2:0]  w_d, w_succ;
    logic [7:0]  w_t;
    logic [13:0] w_open;
    logic        w_set_pattern, w_set_seq, w_set_time, w_set_conflict;
    logic        w_nxt_pattern, w_nxt_seq, w_nxt_time, w_nxt_conflict;
    logic        w_to_track, w_to_sync, w_cycle_inc;

    function automatic logic all_is(input logic [41:0] v, input logic [13:0] m,
                                    input logic [2:0] code);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 14; i++)
            if (m[i] && (v[3*i +: 3] != code)) ok = 1'b0;
        return ok;
    endfunction

    always_comb begin
        w_d = PH_INV;
        if (all_is(r_lights_q, M_A, GRN) && all_is(r_lights_q, M_B | M_C, RED))      w_d = 3'd0;
        else if (all_is(r_lights_q, M_A, YEL) && all_is(r_lights_q, M_B | M_C, RED)) w_d = 3'd1;
        else if (all_is(r_lights_q, M_B, GRN) && all_is(r_lights_q, M_A | M_C, RED)) w_d = 3'd2;
        else if (all_is(r_lights_q, M_B, YEL) && all_is(r_lights_q, M_A | M_C, RED)) w_d = 3'd3;
        else if (all_is(r_lights_q, M_VEH, RED) && all_is(r_lights_q, M_PED, GRN))   w_d = 3'd4;
        else if (all_is(r_lights_q, M_VEH, RED) && all_is(r_lights_q, M_S6G, GRN) &&
                 all_is(r_lights_q, M_S6Y, YEL))                                      w_d = 3'd5;

        for (int i = 0; i < 14; i++) w_open[i] = (r_lights_q[3*i +: 3] != RED);
        // The all-zero lights_q left by reset would read as a conflict, so wait for real data
        w_set_conflict = r_q_vld &&
                         (((|(w_open & 14'h0005)) && (|(w_open & M_X1))) ||
                          ((|(w_open & 14'h000A)) && (|(w_open & M_X2))));

        w_succ = (r_phase == 3'd5) ? 3'd0 : r_phase + 3'd1;
        case (r_phase)
            3'd0:    w_t = 8'(T_S1);
            3'd1:    w_t = 8'(T_S2);
            3'd2:    w_t = 8'(T_S3);
            3'd3:    w_t = 8'(T_S4);
            3'd4:    w_t = 8'(T_S5);
            default: w_t = 8'(T_S6);
        endcase

        w_set_pattern = 1'b0;
        w_set_seq     = 1'b0;
        w_set_time    = 1'b0;
        w_to_track    = 1'b0;
        w_to_sync     = 1'b0;
        w_cycle_inc   = 1'b0;
        case (r_state)
            SYNC: begin
                if (w_d != PH_INV && r_phase != PH_INV && w_d != r_phase) begin
                    if (w_d == w_succ) w_to_track = 1'b1;
                    else               w_set_seq  = 1'b1;
                end
            end
            TRACK: begin
                if (w_d == PH_INV) begin
                    w_set_pattern = 1'b1;
                    w_to_sync     = 1'b1;
                end else if (w_d == r_phase) begin
                    w_set_time = (r_dwell == w_t);
                end else if (w_d == w_succ) begin
                    w_set_time  = (r_dwell < w_t);
                    w_cycle_inc = (r_phase == 3'd5);
                end else begin
                    w_set_seq = 1'b1;
                    w_to_sync = 1'b1;
                end
            end
        endcase

        // A new error outranks a coincident clear
        w_nxt_pattern  = w_set_pattern  | (r_err_pattern  & ~mon.clr_err);
        w_nxt_seq      = w_set_seq      | (r_err_seq      & ~mon.clr_err);
        w_nxt_time     = w_set_time     | (r_err_time     & ~mon.clr_err);
        w_nxt_conflict = w_set_conflict | (r_err_conflict & ~mon.clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= SYNC;
            r_lights_q     <= '0;
            r_q_vld        <= 1'b0;
            r_phase        <= PH_INV;
            r_phase_valid  <= 1'b0;
            r_locked       <= 1'b0;
            r_dwell        <= '0;
            r_err_pattern  <= 1'b0;
            r_err_seq      <= 1'b0;
            r_err_time     <= 1'b0;
            r_err_conflict <= 1'b0;
            r_fault        <= 1'b0;
            r_err_pulse    <= 1'b0;
            r_cycles       <= '0;
        end else begin
            r_lights_q     <= mon.lights;
            r_q_vld        <= 1'b1;
            r_phase        <= w_d;
            r_phase_valid  <= (w_d != PH_INV);
            r_err_pattern  <= w_nxt_pattern;
            r_err_seq      <= w_nxt_seq;
            r_err_time     <= w_nxt_time;
            r_err_conflict <= w_nxt_conflict;
            r_fault        <= w_nxt_pattern | w_nxt_seq | w_nxt_time | w_nxt_conflict;
            r_err_pulse    <= w_set_pattern | w_set_seq | w_set_time | w_set_conflict;
            if (w_cycle_inc) r_cycles <= r_cycles + 16'd1;
            case (r_state)
                SYNC: begin
                    if (w_to_track) begin
                        r_state  <= TRACK;
                        r_locked <= 1'b1;
                        r_dwell  <= 8'd1;
                    end
                end
                TRACK: begin
                    if (w_to_sync) begin
                        r_state  <= SYNC;
                        r_locked <= 1'b0;
                        r_dwell  <= 8'd0;
                    end else if (w_d == r_phase) begin
                        if (r_dwell != 8'hFF) r_dwell <= r_dwell + 8'd1;
                    end else begin
                        r_dwell <= 8'd1;
                    end
                end
            endcase
        end
    end

    assign mon.phase        = r_phase;
    assign mon.phase_valid  = r_phase_valid;
    assign mon.locked       = r_locked;
    assign mon.err_pattern  = r_err_pattern;
    assign mon.err_seq      = r_err_seq;
    assign mon.err_time     = r_err_time;
    assign mon.err_conflict = r_err_conflict;
    assign mon.fault        = r_fault;
    assign mon.err_pulse    = r_err_pulse;
    assign mon.cycles_done  = r_cycles;
endmodule

// File: tb/tb_semaforo_monitor.sv
// Directed bench for semaforo_monitor: lights change just after a falling edge, outputs read on falling edges.
module tb_semaforo_monitor;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam int LA[6]  = '{0, 2, 5, 7, 10, 12};
    localparam int LB[6]  = '{1, 3, 4, 6, 9, 11};
    localparam int LG6[4] = '{5, 7, 10, 12};
    localparam int DW[6]  = '{31, 4, 31, 4, 16, 4};

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pulse_cnt = 0;
    int   base;

    semaforo_monitor_if mon_if();
    semaforo_monitor dut (.clk(clk), .rst(rst), .mon(mon_if));

    always #5 clk = ~clk;
    always @(negedge clk) if (mon_if.err_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;

    function automatic logic [41:0] pat(input int s);
        logic [41:0] v;
        v = '0;
        for (int i = 0; i < 14; i++) v[3*i +: 3] = RED;
        case (s)
            0: for (int i = 0; i < 6; i++) v[3*LA[i] +: 3] = GRN;
            1: for (int i = 0; i < 6; i++) v[3*LA[i] +: 3] = YEL;
            2: for (int i = 0; i < 6; i++) v[3*LB[i] +: 3] = GRN;
            3: for (int i = 0; i < 6; i++) v[3*LB[i] +: 3] = YEL;
            4: for (int i = 4; i < 14; i++) v[3*i +: 3] = GRN;
            default: begin
                for (int i = 4; i < 14; i++) v[3*i +: 3] = YEL;
                for (int i = 0; i < 4; i++) v[3*LG6[i] +: 3] = GRN;
            end
        endcase
        return v;
    endfunction

    function automatic logic [41:0] setl(input logic [41:0] v, input int lane, input logic [2:0] code);
        logic [41:0] r;
        r = v;
        r[3*lane +: 3] = code;
        return r;
    endfunction

    task automatic hold(input int s, input int n);
        mon_if.lights = pat(s);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int s);
        rst = 1'b1;
        mon_if.clr_err = 1'b0;
        mon_if.lights = pat(s);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        mon_if.clr_err = 1'b0;
        mon_if.lights = pat(0);
        repeat (3) @(negedge clk);
        n_cmp++; if (mon_if.phase !== 3'd7) begin n_bad++; $display("FAIL rst_phase: got %0d want 7", mon_if.phase); end
        n_cmp++; if (mon_if.phase_valid !== 1'b0) begin n_bad++; $display("FAIL rst_phase_valid: got %b want 0", mon_if.phase_valid); end
        n_cmp++; if (mon_if.locked !== 1'b0) begin n_bad++; $display("FAIL rst_locked: got %b want 0", mon_if.locked); end
        n_cmp++; if ({mon_if.err_pattern, mon_if.err_seq, mon_if.err_time, mon_if.err_conflict} !== 4'b0000) begin
            n_bad++; $display("FAIL rst_flags: got %b want 0000", {mon_if.err_pattern, mon_if.err_seq, mon_if.err_time, mon_if.err_conflict}); end
        n_cmp++; if (mon_if.fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %b want 0", mon_if.fault); end
        n_cmp++; if (mon_if.err_pulse !== 1'b0) begin n_bad++; $display("FAIL rst_pulse: got %b want 0", mon_if.err_pulse); end
        n_cmp++; if (mon_if.cycles_done !== 16'd0) begin n_bad++; $display("FAIL rst_cycles: got %0d want 0", mon_if.cycles_done); end
        rst = 1'b0;
    endtask

    task automatic test_ideal_sequence;
        #1 base = pulse_cnt;
        hold(0, 31);
        mon_if.lights = pat(1);
        @(negedge clk);
        n_cmp++; if (mon_if.locked !== 1'b0) begin n_bad++; $display("FAIL ideal_lock_early: got %b want 0", mon_if.locked); end
        @(negedge clk);
        n_cmp++; if (mon_if.locked !== 1'b1) begin n_bad++; $display("FAIL ideal_lock: got %b want 1", mon_if.locked); end
        n_cmp++; if (mon_if.phase !== 3'd1) begin n_bad++; $display("FAIL ideal_phase_s2: got %0d want 1", mon_if.phase); end
        repeat (2) @(negedge clk);
        for (int k = 2; k < 6; k++) hold(k, DW[k]);
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 6; k++) hold(k, DW[k]);
        hold(0, 5);
        #1;
        n_cmp++; if (mon_if.cycles_done !== 16'd3) begin n_bad++; $display("FAIL ideal_cycles: got %0d want 3", mon_if.cycles_done); end
        n_cmp++; if (mon_if.fault !== 1'b0) begin n_bad++; $display("FAIL ideal_fault: got %b want 0", mon_if.fault); end
        n_cmp++; if (mon_if.locked !== 1'b1) begin n_bad++; $display("FAIL ideal_locked_end: got %b want 1", mon_if.locked); end
        n_cmp++; if (mon_if.phase !== 3'd0 || mon_if.phase_valid !== 1'b1) begin
            n_bad++; $display("FAIL ideal_phase_end: got %0d/%b want 0/1", mon_if.phase, mon_if.phase_valid); end
        n_cmp++; if (pulse_cnt - base !== 0) begin n_bad++; $display("FAIL ideal_pulses: got %0d want 0", pulse_cnt - base); end
    endtask

    task automatic test_overstay;
        do_reset(5);
        hold(5, 3);
        #1 base = pulse_cnt;
        mon_if.lights = pat(0);
        repeat (32) @(negedge clk);
        n_cmp++; if (mon_if.err_time !== 1'b0) begin n_bad++; $display("FAIL over_early: got %b want 0", mon_if.err_time); end
        n_cmp++; if (mon_if.locked !== 1'b1) begin n_bad++; $display("FAIL over_locked: got %b want 1", mon_if.locked); end
        @(negedge clk);
        n_cmp++; if (mon_if.err_time !== 1'b1) begin n_bad++; $display("FAIL over_err_time: got %b want 1", mon_if.err_time); end
        n_cmp++; if (mon_if.fault !== 1'b1) begin n_bad++; $display("FAIL over_fault: got %b want 1", mon_if.fault); end
        n_cmp++; if (mon_if.err_pulse !== 1'b1) begin n_bad++; $display("FAIL over_pulse: got %b want 1", mon_if.err_pulse); end
        @(negedge clk);
        n_cmp++; if (mon_if.err_pulse !== 1'b0) begin n_bad++; $display("FAIL over_pulse_end: got %b want 0", mon_if.err_pulse); end
        @(negedge clk);
        #1;
        n_cmp++; if (pulse_cnt - base !== 1) begin n_bad++; $display("FAIL over_pulse_count: got %0d want 1", pulse_cnt - base); end
    endtask

    task automatic test_short_s3;
        do_reset(0);
        hold(0, 3);
        hold(1, 4);
        hold(2, 20);
        n_cmp++; if (mon_if.err_time !== 1'b0) begin n_bad++; $display("FAIL short_pre: got %b want 0", mon_if.err_time); end
        mon_if.lights = pat(3);
        repeat (2) @(negedge clk);
        n_cmp++; if (mon_if.err_time !== 1'b1) begin n_bad++; $display("FAIL short_err_time: got %b want 1", mon_if.err_time); end
        n_cmp++; if (mon_if.locked !== 1'b1) begin n_bad++; $display("FAIL short_locked: got %b want 1", mon_if.locked); end
        n_cmp++; if (mon_if.phase !== 3'd3) begin n_bad++; $display("FAIL short_phase: got %0d want 3", mon_if.phase); end
        n_cmp++; if (mon_if.err_seq !== 1'b0) begin n_bad++; $display("FAIL short_seq: got %b want 0", mon_if.err_seq); end
    endtask

    task automatic test_seq_jump;
        do_reset(0);
        hold(0, 3);
        hold(1, 3);
        n_cmp++; if (mon_if.locked !== 1'b1) begin n_bad++; $display("FAIL jump_pre_lock: got %b want 1", mon_if.locked); end
        #1 base = pulse_cnt;
        mon_if.lights = pat(3);
        repeat (2) @(negedge clk);
        n_cmp++; if (mon_if.err_seq !== 1'b1) begin n_bad++; $display("FAIL jump_err_seq: got %b want 1", mon_if.err_seq); end
        n_cmp++; if (mon_if.locked !== 1'b0) begin n_bad++; $display("FAIL jump_unlock: got %b want 0", mon_if.locked); end
        n_cmp++; if (mon_if.phase !== 3'd3) begin n_bad++; $display("FAIL jump_phase: got %0d want 3", mon_if.phase); end
        repeat (2) @(negedge clk);
        mon_if.lights = pat(4);
        repeat (2) @(negedge clk);
        n_cmp++; if (mon_if.locked !== 1'b1) begin n_bad++; $display("FAIL jump_relock: got %b want 1", mon_if.locked); end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (pulse_cnt - base !== 1) begin n_bad++; $display("FAIL jump_pulses: got %0d want 1", pulse_cnt - base); end
        n_cmp++; if ({mon_if.err_pattern, mon_if.err_time, mon_if.err_conflict} !== 3'b000) begin
            n_bad++; $display("FAIL jump_other_flags: got %b want 000", {mon_if.err_pattern, mon_if.err_time, mon_if.err_conflict}); end
    endtask

    task automatic test_pattern_conflict;
        do_reset(5);
        hold(5, 3);
        hold(0, 5);
        n_cmp++; if (mon_if.locked !== 1'b1) begin n_bad++; $display("FAIL pat_pre_lock: got %b want 1", mon_if.locked); end
        mon_if.lights = setl(pat(0), 0, 3'b110);
        @(negedge clk);
        mon_if.lights = pat(0);
        @(negedge clk);
        n_cmp++; if (mon_if.phase !== 3'd7 || mon_if.phase_valid !== 1'b0) begin
            n_bad++; $display("FAIL pat_phase: got %0d/%b want 7/0", mon_if.phase, mon_if.phase_valid); end
        n_cmp++; if (mon_if.err_pattern !== 1'b1) begin n_bad++; $display("FAIL pat_err: got %b want 1", mon_if.err_pattern); end
        n_cmp++; if (mon_if.locked !== 1'b0) begin n_bad++; $display("FAIL pat_unlock: got %b want 0", mon_if.locked); end
        n_cmp++; if (mon_if.err_conflict !== 1'b0) begin n_bad++; $display("FAIL pat_no_conflict: got %b want 0", mon_if.err_conflict); end
        repeat (2) @(negedge clk);
        mon_if.lights = setl(pat(0), 1, GRN);
        @(negedge clk);
        mon_if.lights = pat(0);
        @(negedge clk);
        n_cmp++; if (mon_if.err_conflict !== 1'b1) begin n_bad++; $display("FAIL conf_err: got %b want 1", mon_if.err_conflict); end
        n_cmp++; if (mon_if.fault !== 1'b1) begin n_bad++; $display("FAIL conf_fault: got %b want 1", mon_if.fault); end
        repeat (2) @(negedge clk);
        mon_if.clr_err = 1'b1;
        @(negedge clk);
        mon_if.clr_err = 1'b0;
        n_cmp++; if ({mon_if.err_pattern, mon_if.err_seq, mon_if.err_time, mon_if.err_conflict} !== 4'b0000) begin
            n_bad++; $display("FAIL clr_flags: got %b want 0000", {mon_if.err_pattern, mon_if.err_seq, mon_if.err_time, mon_if.err_conflict}); end
        n_cmp++; if (mon_if.fault !== 1'b0) begin n_bad++; $display("FAIL clr_fault: got %b want 0", mon_if.fault); end
    endtask

    task automatic test_reset_mid_and_clr_collision;
        do_reset(0);
        hold(0, 3);
        hold(2, 3);
        hold(3, 3);
        hold(4, 6);
        n_cmp++; if (mon_if.locked !== 1'b1) begin n_bad++; $display("FAIL mid_pre_lock: got %b want 1", mon_if.locked); end
        n_cmp++; if ({mon_if.err_seq, mon_if.err_time, mon_if.fault} !== 3'b111) begin
            n_bad++; $display("FAIL mid_pre_flags: got %b want 111", {mon_if.err_seq, mon_if.err_time, mon_if.fault}); end
        rst = 1'b1;
        #1;
        n_cmp++; if (mon_if.phase !== 3'd7 || mon_if.phase_valid !== 1'b0 || mon_if.locked !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_state: got %0d/%b/%b want 7/0/0", mon_if.phase, mon_if.phase_valid, mon_if.locked); end
        n_cmp++; if ({mon_if.err_pattern, mon_if.err_seq, mon_if.err_time, mon_if.err_conflict, mon_if.fault, mon_if.err_pulse} !== 6'b0) begin
            n_bad++; $display("FAIL mid_rst_flags: got %b want 000000",
                {mon_if.err_pattern, mon_if.err_seq, mon_if.err_time, mon_if.err_conflict, mon_if.fault, mon_if.err_pulse}); end
        n_cmp++; if (mon_if.cycles_done !== 16'd0) begin n_bad++; $display("FAIL mid_rst_cycles: got %0d want 0", mon_if.cycles_done); end
        @(negedge clk);
        rst = 1'b0;
        hold(4, 5);
        n_cmp++; if (mon_if.locked !== 1'b0 || mon_if.phase !== 3'd4) begin
            n_bad++; $display("FAIL mid_no_relock: got %b/%0d want 0/4", mon_if.locked, mon_if.phase); end
        n_cmp++; if (mon_if.fault !== 1'b0) begin n_bad++; $display("FAIL mid_post_fault: got %b want 0", mon_if.fault); end
        mon_if.lights = pat(5);
        repeat (2) @(negedge clk);
        n_cmp++; if (mon_if.locked !== 1'b1) begin n_bad++; $display("FAIL mid_relock: got %b want 1", mon_if.locked); end
        mon_if.lights = setl(pat(5), 0, GRN);
        @(negedge clk);
        mon_if.lights = pat(5);
        mon_if.clr_err = 1'b1;
        @(negedge clk);
        mon_if.clr_err = 1'b0;
        n_cmp++; if (mon_if.err_conflict !== 1'b1) begin n_bad++; $display("FAIL coll_conflict: got %b want 1", mon_if.err_conflict); end
        n_cmp++; if (mon_if.fault !== 1'b1) begin n_bad++; $display("FAIL coll_fault: got %b want 1", mon_if.fault); end
        n_cmp++; if (mon_if.err_pulse !== 1'b1) begin n_bad++; $display("FAIL coll_pulse: got %b want 1", mon_if.err_pulse); end
    endtask

    initial begin
        rst = 1'b1;
        mon_if.clr_err = 1'b0;
        mon_if.lights = pat(0);
        @(negedge clk);
        test_reset();
        test_ideal_sequence();
        test_overstay();
        test_short_s3();
        test_seq_jump();
        test_pattern_conflict();
        test_reset_mid_and_clr_collision();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/semaforo_monitor.md
Name: semaforo_monitor

Overview:
- Receive-side checker for the intersection light controller: samples all 14 light codes, decodes them back into the controller phase (S1..S6), and checks pattern legality, phase order, phase dwell time and conflicting right-of-way.
- Sits beside the controller outputs (or on the lamp-driver side). Reports sticky errors and a fault flag for fail-safe logic and the bench scoreboard.
- Light code per lane: 3'b100 red, 3'b010 yellow, 3'b001 green. Any other value is illegal.

Parameters:
- T_S1, default 31, expected dwell of S1 in clk cycles (all T_* must be 1..254)
- T_S2, default 4, expected dwell of S2
- T_S3, default 31, expected dwell of S3
- T_S4, default 4, expected dwell of S4
- T_S5, default 16, expected dwell of S5
- T_S6, default 4, expected dwell of S6

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- lights  in  42  packed lanes; lane i = lights[3i+2:3i]; i: 0 F1, 1 F2, 2 F6, 3 F9, 4..13 P1..P10
- clr_err  in  1  synchronous clear of sticky error flags
- phase  out  3  decoded phase, 0..5 = S1..S6, 7 = invalid
- phase_valid  out  1  phase != 7
- locked  out  1  FSM in TRACK
- err_pattern  out  1  sticky: undecodable pattern seen
- err_seq  out  1  sticky: illegal phase successor
- err_time  out  1  sticky: dwell mismatch
- err_conflict  out  1  sticky: conflicting non-red lanes
- fault  out  1  OR of the four sticky flags
- err_pulse  out  1  one-cycle pulse on any new error event
- cycles_done  out  16  count of completed S6->S1 transitions in TRACK, wraps at 65535->0

Behaviour:
- Reset values: phase=7, phase_valid=0, locked=0, all err_*=0, fault=0, err_pulse=0, cycles_done=0, dwell=0, internal lights_q=0.
- Pipeline:
  - Edge n registers lights into lights_q.
  - Edge n+1 registers decode(lights_q) into phase and updates FSM, dwell and flags.
  - Input change to output change is 2 cycles.
- Lane groups: A={F1,P2,P4,F6,P7,P9}, B={F2,P1,P3,F9,P6,P8}, C={P5,P10}.
- Decode patterns:
  - S1: A green, B red, C red.
  - S2: A yellow, B red, C red.
  - S3: A red, B green, C red.
  - S4: A red, B yellow, C red.
  - S5: F1,F2,F6,F9 red; all P green.
  - S6: vehicles red; P2,P4,P7,P9 green; P1,P3,P5,P6,P8,P10 yellow.
  - Anything else decodes to 7.
- Conflict check (independent of decode): a lane is "open" if its code != 3'b100. err_conflict is set when either holds:
  - F1 or F6 open AND any of {F2,F9,P1,P3,P5,P6,P8,P10} open;
  - F2 or F9 open AND any of {F1,F6,P2,P4,P5,P7,P9,P10} open.
- Legal successor of Sk is S((k+1) mod 6).
- FSM states SYNC and TRACK. Let d = decode(lights_q) and p = current phase register.
  - SYNC:
    - d == 7: stay.
    - d valid and (p invalid or d == p): stay.
    - d != p, both valid, d is the legal successor of p: go to TRACK, dwell<=1.
    - d != p, both valid, d is not the legal successor: set err_seq, stay in SYNC.
    - Dwell is not checked in SYNC.
  - TRACK, per edge:
    - d == 7: set err_pattern, go to SYNC, dwell<=0.
    - d == p: if dwell == T[p], set err_time (overstay, once per dwell). dwell increments, saturating at 255.
    - d != p, d legal successor: if dwell < T[p], set err_time (understay). dwell<=1. If p==S6, cycles_done++.
    - d != p, d not legal successor: set err_seq, go to SYNC.
- Sticky flags clear on clr_err. If clr_err and a new error arrive in the same cycle, the new error wins (flag ends up 1).
- err_pulse=1 for one cycle whenever any err_* set condition occurs, including flags already set.
- fault is registered with the flags (same cycle).
- Reset mid-operation returns everything to reset values; lock requires a fresh legal transition.

Test Plan:
- Ideal sequence with default T_*, starting S1, 3 full 90-cycle periods then S1 -> locked=1 two cycles after first S1->S2, no errors, cycles_done=3.
- Hold S1 for 35 cycles in TRACK -> err_time=1, fault=1 at dwell 31->32 edge, single err_pulse.
- S3 shortened to 20 cycles -> err_time set on S3->S4 transition, locked stays 1.
- Jump S2->S4 while locked -> err_seq=1, locked=0; relock on next S4->S5 with no new errors.
- Set F1=3'b110 for one cycle -> phase=7, err_pattern=1, locked=0. Then F1 green and F2 green together -> err_conflict=1. Then clr_err asserted alone -> all flags 0, fault=0.
- Assert rst mid-S5 -> all outputs at reset values. clr_err coincident with an injected conflict -> err_conflict remains 1.
